// File: rtl/pc_gen_pkg.sv
// Shared definitions for the IF-stage program-counter generator:
// FSM state encodings, default reset vector and chip-enable levels.
package pc_gen_pkg;

    // Fetch-side FSM states
    typedef enum logic [1:0] {
        PC_S_OFF  = 2'd0,  // held in/just out of reset, ROM disabled
        PC_S_RUN  = 2'd1,  // fetching, no pending branch
        PC_S_PEND = 2'd2   // fetching (stalled), branch target parked
    } pc_state_t;

    // Default reset vector; first fetch address after reset
    localparam logic [31:0] PC_DEFAULT_RESET_VEC = 32'h0000_0000;

    // Instruction ROM chip-enable levels
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    // True when the FSM is in a fetching state
    function automatic logic pc_state_active(input pc_state_t s);
        return (s == PC_S_RUN) || (s == PC_S_PEND);
    endfunction

endpackage

// File: rtl/pc_pend_buf.sv
// One-entry pending-branch buffer: holds an already-aligned branch target
// (plus whether the raw target was misaligned) captured during a stall.
// A newer load overwrites the entry; clear wins over load.
module pc_pend_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] target_in,
    input  logic              misalign_in,
    output logic              valid,
    output logic [ADDR_W-1:0] target,
    output logic              misalign
);

    // Entry register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid    <= 1'b0;
            target   <= '0;
            misalign <= 1'b0;
        end else if (clear) begin
            valid    <= 1'b0;
            target   <= '0;
            misalign <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            target   <= target_in;
            misalign <= misalign_in;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage. Sequential increment with
// stall, branch redirect, flush redirect (highest priority) and a
// one-entry pending-branch buffer so branches resolved during a stall
// are applied once the stall releases.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(PC_DEFAULT_RESET_VEC),
    parameter int unsigned       INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              redirect_o,
    output logic              misalign_o
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

    pc_state_t state;

    logic [ADDR_W-1:0] branch_aligned;
    logic              branch_mis;
    logic [ADDR_W-1:0] flush_aligned;
    logic              flush_mis;

    logic              buf_load;
    logic              buf_clear;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic              pend_mis;
    logic              pend_apply;

    // Target alignment and misalignment detection on the raw inputs
    always_comb begin
        branch_aligned = branch_target_i & ~ALIGN_MASK;
        branch_mis     = |(branch_target_i & ALIGN_MASK);
        flush_aligned  = new_pc_i & ~ALIGN_MASK;
        flush_mis      = |(new_pc_i & ALIGN_MASK);
    end

    // Pending-buffer control mirrors the FSM priority: flush clears,
    // stall+branch (re)loads, leaving S_PEND without stall consumes
    always_comb begin
        pend_apply = (state == PC_S_PEND) && pend_valid && !stall_i && !flush_i;
        buf_load   = pc_state_active(state) && !flush_i && stall_i && branch_flag_i;
        buf_clear  = pc_state_active(state) && (flush_i || pend_apply);
    end

    pc_pend_buf #(
        .ADDR_W(ADDR_W)
    ) u_pend_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .target_in  (branch_aligned),
        .misalign_in(branch_mis),
        .valid      (pend_valid),
        .target     (pend_target),
        .misalign   (pend_mis)
    );

    // FSM with next-PC selection and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= PC_S_OFF;
            pc_o       <= RESET_PC;
            ce_o       <= ChipDisable;
            redirect_o <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            redirect_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                PC_S_OFF: begin
                    // pc_o stays at RESET_PC so it is the first fetch
                    state <= PC_S_RUN;
                    ce_o  <= ChipEnable;
                end
                PC_S_RUN, PC_S_PEND: begin
                    ce_o <= ChipEnable;
                    if (flush_i) begin
                        pc_o       <= flush_aligned;
                        redirect_o <= 1'b1;
                        misalign_o <= flush_mis;
                        state      <= PC_S_RUN;
                    end else if (stall_i) begin
                        if (branch_flag_i) begin
                            state <= PC_S_PEND;
                        end
                    end else if (pend_apply) begin
                        // Any branch_flag_i arriving here is dropped
                        pc_o       <= pend_target;
                        redirect_o <= 1'b1;
                        misalign_o <= pend_mis;
                        state      <= PC_S_RUN;
                    end else if (branch_flag_i) begin
                        pc_o       <= branch_aligned;
                        redirect_o <= 1'b1;
                        misalign_o <= branch_mis;
                        state      <= PC_S_RUN;
                    end else begin
                        pc_o  <= pc_o + PC_STEP;
                        state <= PC_S_RUN;
                    end
                end
                default: begin
                    state <= PC_S_OFF;
                    ce_o  <= ChipDisable;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen (ADDR_W=32, RESET_PC=0, INST_BYTES=4):
// behavioural model compared every cycle plus hand-computed literals.
module tb_pc_gen;

    localparam int unsigned ADDR_W     = 32;
    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int unsigned INST_BYTES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic [31:0] pc_o;
    logic        ce_o;
    logic        redirect_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    pc_gen #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RESET_PC),
        .INST_BYTES(INST_BYTES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .flush_i        (flush_i),
        .new_pc_i       (new_pc_i),
        .pc_o           (pc_o),
        .ce_o           (ce_o),
        .redirect_o     (redirect_o),
        .misalign_o     (misalign_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_known = 0;
    bit          m_on;
    longint      m_pc;
    bit          m_has_pend;
    longint      m_pend_raw;
    bit          m_redir;
    bit          m_mis;

    function automatic longint align_down(input longint a);
        return a - (a % INST_BYTES);
    endfunction

    // Model update on the edge, compare 1 time unit later
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m_known = 1; m_on = 0; m_pc = RESET_PC; m_has_pend = 0;
            m_redir = 0; m_mis = 0;
        end else if (m_known) begin
            m_redir = 0; m_mis = 0;
            if (!m_on) begin
                m_on = 1;
            end else if (flush_i) begin
                m_pc = align_down(longint'(new_pc_i)); m_has_pend = 0;
                m_redir = 1; m_mis = (new_pc_i % INST_BYTES) != 0;
            end else if (stall_i) begin
                if (branch_flag_i) begin
                    m_has_pend = 1; m_pend_raw = longint'(branch_target_i);
                end
            end else if (m_has_pend) begin
                m_pc = align_down(m_pend_raw); m_has_pend = 0;
                m_redir = 1; m_mis = (m_pend_raw % INST_BYTES) != 0;
            end else if (branch_flag_i) begin
                m_pc = align_down(longint'(branch_target_i));
                m_redir = 1; m_mis = (branch_target_i % INST_BYTES) != 0;
            end else begin
                m_pc = (m_pc + INST_BYTES) % 64'h1_0000_0000;
            end
        end
        #1;
        if (m_known) begin
            checks++;
            if (pc_o !== 32'(m_pc) || ce_o !== m_on ||
                redirect_o !== m_redir || misalign_o !== m_mis) begin
                errors++;
                $display("FAIL model t=%0t: pc=%h ce=%b red=%b mis=%b, expected pc=%h ce=%b red=%b mis=%b",
                         $time, pc_o, ce_o, redirect_o, misalign_o,
                         32'(m_pc), m_on, m_redir, m_mis);
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Wait one edge; inputs set afterwards are away from the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [31:0] pc,
                              input logic ce, input logic red, input logic mis);
        lit({name, ".pc"}, pc_o, pc);
        lit({name, ".ce"}, 32'(ce_o), 32'(ce));
        lit({name, ".redirect"}, 32'(redirect_o), 32'(red));
        lit({name, ".misalign"}, 32'(misalign_o), 32'(mis));
    endtask

    initial begin
        rst = 0; stall_i = 0; branch_flag_i = 0; branch_target_i = '0;
        flush_i = 0; new_pc_i = '0;
        tick(); tick();
        expect_out("reset", 32'h0, 0, 0, 0);

        // Release; a branch during S_OFF must be ignored
        rst = 1; branch_flag_i = 1; branch_target_i = 32'h900;
        tick(); expect_out("edge1", 32'h0, 1, 0, 0);
        branch_flag_i = 0;
        tick(); expect_out("edge2", 32'h4, 1, 0, 0);
        tick(); expect_out("edge3", 32'h8, 1, 0, 0);
        tick(); tick(); lit("at_0x10", pc_o, 32'h10);

        // Plain branch
        branch_flag_i = 1; branch_target_i = 32'h100;
        tick(); expect_out("branch", 32'h100, 1, 1, 0);
        branch_flag_i = 0;
        tick(); expect_out("branch_next", 32'h104, 1, 0, 0);

        // Branch under 3-cycle stall
        stall_i = 1; branch_flag_i = 1; branch_target_i = 32'h200;
        tick(); lit("stall1.pc", pc_o, 32'h104);
        branch_flag_i = 0;
        tick(); tick(); expect_out("stall3", 32'h104, 1, 0, 0);
        stall_i = 0;
        tick(); expect_out("pend_apply", 32'h200, 1, 1, 0);
        tick(); lit("pend_next.pc", pc_o, 32'h204);

        // Flush beats stall and pending
        stall_i = 1; branch_flag_i = 1; branch_target_i = 32'h200;
        tick();
        branch_flag_i = 0; flush_i = 1; new_pc_i = 32'h180;
        tick(); expect_out("flush", 32'h180, 1, 1, 0);
        flush_i = 0;
        tick(); lit("flush_hold.pc", pc_o, 32'h180);
        stall_i = 0;
        tick(); expect_out("flush_release", 32'h184, 1, 0, 0);

        // Wrap-around
        flush_i = 1; new_pc_i = 32'hFFFF_FFF8;
        tick(); flush_i = 0;
        tick(); lit("pre_wrap.pc", pc_o, 32'hFFFF_FFFC);
        tick(); expect_out("wrap", 32'h0, 1, 0, 0);

        // Misaligned direct branch
        branch_flag_i = 1; branch_target_i = 32'h102;
        tick(); expect_out("misalign", 32'h100, 1, 1, 1);
        branch_flag_i = 0;
        tick(); expect_out("misalign_next", 32'h104, 1, 0, 0);

        // Misaligned pending branch, overwritten by a newer one
        stall_i = 1; branch_flag_i = 1; branch_target_i = 32'h400;
        tick(); branch_target_i = 32'h303;
        tick(); branch_flag_i = 0; stall_i = 0;
        tick(); expect_out("pend_overwrite", 32'h300, 1, 1, 1);

        // Reset while pending, with stall and flush asserted
        stall_i = 1; branch_flag_i = 1; branch_target_i = 32'h600;
        tick();
        branch_flag_i = 0; flush_i = 1; new_pc_i = 32'h700; rst = 0;
        tick(); expect_out("mid_reset", 32'h0, 0, 0, 0);
        rst = 1; flush_i = 0; stall_i = 0;
        tick(); expect_out("mid_release", 32'h0, 1, 0, 0);
        tick(); expect_out("mid_run", 32'h4, 1, 0, 0);
        tick(); lit("mid_run2.pc", pc_o, 32'h8);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the IF stage; successor to the fixed 32-bit free-running PC register.
- Adds:
  - a configurable reset vector, address width and instruction size;
  - pipeline stall;
  - branch redirect;
  - exception/flush redirect;
  - a one-entry pending-branch buffer, so a branch resolved during a stall is not lost.
- Drives instruction-ROM address and chip-enable directly.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- RESET_PC, 0, PC value loaded by reset; also the first fetch address.
- INST_BYTES, 4, sequential increment; power of two ≥1; low log2(INST_BYTES) bits of every target are alignment bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-low (rst==0 at a rising edge resets)
- stall_i  input  1  hold PC (from ctrl stall vector, IF bit)
- branch_flag_i  input  1  branch/jump taken, one-cycle pulse from ID
- branch_target_i  input  ADDR_W  branch/jump target
- flush_i  input  1  exception/eret redirect, highest priority
- new_pc_i  input  ADDR_W  flush target (exception vector / EPC)
- pc_o  output  ADDR_W  current fetch address
- ce_o  output  1  instruction memory chip enable
- redirect_o  output  1  registered pulse: pc_o changed from a non-sequential source this cycle
- misalign_o  output  1  registered pulse: accepted target had nonzero alignment bits

Behaviour:
- Reset (rst==0 at edge), regardless of other inputs:
  - ce_o<=0, pc_o<=RESET_PC, redirect_o<=0, misalign_o<=0;
  - pending buffer cleared;
  - state<=S_OFF.
- States:
  - S_OFF: ce_o=0.
  - S_RUN: ce_o=1, no pending branch.
  - S_PEND: ce_o=1, pending branch held.
- S_OFF:
  - first edge with rst==1 -> S_RUN, ce_o<=1;
  - pc_o stays RESET_PC, so the first fetch is RESET_PC;
  - branch/flush/stall inputs are ignored in S_OFF.
- S_RUN / S_PEND: priority evaluated each edge, highest first.
  1. flush_i: pc_o<=new_pc_i; pending cleared; state<=S_RUN; redirect_o<=1.
  2. stall_i: pc_o held.
     - If branch_flag_i: capture branch_target_i into pending, state<=S_PEND.
     - A second branch while already pending overwrites the buffer (newest wins).
  3. S_PEND and not stall: pc_o<=pending target; state<=S_RUN; redirect_o<=1.
     - A simultaneous branch_flag_i is dropped; ID must not issue one here.
  4. branch_flag_i: pc_o<=branch_target_i; redirect_o<=1.
  5. otherwise: pc_o<=pc_o+INST_BYTES.
- Redirect pulses:
  - redirect_o is a one-cycle pulse, 0 in all other cycles.
  - misalign_o pulses together with any redirect whose target has nonzero alignment bits.
- Arithmetic and alignment:
  - Increment is modulo 2^ADDR_W; wrap-around from all-ones is legal and not flagged.
  - Alignment bits are forced to 0 when a target is loaded into pc_o or the pending buffer.
  - misalign_o is evaluated on the raw target when it is loaded into pc_o.
- Latency:
  - redirect takes effect on pc_o at the edge following the input, i.e. 1 cycle;
  - pending branch appears at the edge after stall_i falls.
- Reset mid-operation overrides flush/stall/pending in the same edge.

Decomposition:
- Shared package/define file holds:
  - state encodings PC_S_OFF=2'd0, PC_S_RUN=2'd1, PC_S_PEND=2'd2;
  - default reset vector constant;
  - ChipEnable/ChipDisable constants.
- One natural sub-module: pc_pend_buf, the one-entry target register with valid/overwrite/clear.
- Next-PC mux and FSM stay in pc_gen.

Test Plan:
- Reset release, ADDR_W=32, RESET_PC=0: after rst 0->1, expected behaviour by edge after release:
  - edge1: ce_o=1, pc_o=0;
  - edge2: pc_o=4;
  - edge3: pc_o=8;
  - redirect_o=0 throughout.
- Branch, free-running at pc_o=0x10: branch_flag_i=1, target=0x100 for one cycle -> pc_o=0x100 and redirect_o=1 next edge, then 0x104.
- Branch under stall:
  - stall_i=1 for 3 cycles with branch 0x200 in the 1st stall cycle -> pc_o held, state=S_PEND.
  - First edge after stall release -> pc_o=0x200, redirect_o=1.
- Flush beats all: stall_i=1, pending 0x200, flush_i=1, new_pc_i=0x180 -> pc_o=0x180, pending cleared, later stall release gives 0x184.
- Boundaries:
  - pc_o=0xFFFFFFFC, no inputs -> pc_o=0x0, no flag.
  - branch to 0x102 -> pc_o=0x100, misalign_o=1 for one cycle.
- Reset mid-pending: rst=0 while in S_PEND with stall/flush asserted -> ce_o=0, pc_o=RESET_PC; after release, pending target never appears.
